// File: rtl/formater.sv
// Packet formatter: collects per-channel words into a FIFO, then requests the
// downstream bus and streams the packet out with start/end markers once granted.
module formater #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        a2f_val_i,
    input  logic [1:0]  a2f_id_i,
    input  logic [31:0] a2f_dat_i,
    input  logic [2:0]  slv0_len_i,
    input  logic [2:0]  slv1_len_i,
    input  logic [2:0]  slv2_len_i,
    output logic        f2a_ack_o,
    output logic [1:0]  fmt_chid_o,
    output logic [4:0]  fmt_length_o,
    output logic        fmt_req_o,
    input  logic        fmt_grant_i,
    output logic [31:0] fmt_data_o,
    output logic        fmt_start_o,
    output logic        fmt_end_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REQ     = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  length_q, length_d;
    logic [1:0]  chid_q, chid_d;
    logic        req_q, req_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_q [FIFO_DEPTH];

    logic        ack;
    logic [2:0]  len_code;
    logic [4:0]  new_len;
    logic [4:0]  pkt_len;

    function automatic logic [4:0] decode_len(input logic [2:0] code);
        case (code)
            3'd0:    return 5'd4;
            3'd1:    return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    always_comb begin
        case (a2f_id_i)
            2'd0:    len_code = slv0_len_i;
            2'd1:    len_code = slv1_len_i;
            default: len_code = slv2_len_i;
        endcase
    end

    assign new_len = decode_len(len_code);
    // Length is only taken from the code on the first word; later code changes are ignored.
    assign pkt_len = (cnt_q == 5'd0) ? new_len : length_q;

    assign ack = a2f_val_i && !rstn_i && (state_q == COLLECT) && (a2f_id_i != 2'd3)
               && ((cnt_q == 5'd0) || (a2f_id_i == chid_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        length_d = length_q;
        chid_d   = chid_q;
        req_d    = req_q;
        data_d   = 32'd0;
        start_d  = 1'b0;
        end_d    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (ack) begin
                    cnt_d = 5'(cnt_q + 5'd1);
                    if (cnt_q == 5'd0) begin
                        chid_d   = a2f_id_i;
                        length_d = new_len;
                    end
                    if (5'(cnt_q + 5'd1) == pkt_len) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (fmt_grant_i) begin
                    state_d  = SEND;
                    req_d    = 1'b0;
                    data_d   = mem_q[0];
                    start_d  = 1'b1;
                    rd_ptr_d = 5'd1;
                end
            end
            SEND: begin
                if (end_q) begin
                    state_d  = COLLECT;
                    cnt_d    = 5'd0;
                    rd_ptr_d = 5'd0;
                end else begin
                    data_d   = mem_q[AW'(rd_ptr_q)];
                    end_d    = (rd_ptr_q == 5'(length_q - 5'd1));
                    rd_ptr_d = 5'(rd_ptr_q + 5'd1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            state_q  <= COLLECT;
            cnt_q    <= 5'd0;
            rd_ptr_q <= 5'd0;
            length_q <= 5'd0;
            chid_q   <= 2'd0;
            req_q    <= 1'b0;
            data_q   <= 32'd0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            length_q <= length_d;
            chid_q   <= chid_d;
            req_q    <= req_d;
            data_q   <= data_d;
            start_q  <= start_d;
            end_q    <= end_d;
        end
    end

    // Storage needs no reset: cnt_q clearing empties it, and reads never pass cnt_q.
    always_ff @(posedge clk_i) begin
        if (ack) begin
            mem_q[AW'(cnt_q)] <= a2f_dat_i;
        end
    end

    assign f2a_ack_o    = ack;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = length_q;
    assign fmt_req_o    = req_q;
    assign fmt_data_o   = data_q;
    assign fmt_start_o  = start_q;
    assign fmt_end_o    = end_q;

endmodule

// File: tb/tb_formater.sv
// Directed self-checking bench for formater: collection, grant handling,
// ack blocking, long packets, channel switching and asynchronous reset.
module tb_formater;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        a2f_val_i;
    logic [1:0]  a2f_id_i;
    logic [31:0] a2f_dat_i;
    logic [2:0]  slv0_len_i, slv1_len_i, slv2_len_i;
    logic        f2a_ack_o;
    logic [1:0]  fmt_chid_o;
    logic [4:0]  fmt_length_o;
    logic        fmt_req_o;
    logic        fmt_grant_i;
    logic [31:0] fmt_data_o;
    logic        fmt_start_o;
    logic        fmt_end_o;

    int n_assert = 0;
    int n_fail   = 0;

    formater #(.FIFO_DEPTH(16)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .a2f_val_i    (a2f_val_i),
        .a2f_id_i     (a2f_id_i),
        .a2f_dat_i    (a2f_dat_i),
        .slv0_len_i   (slv0_len_i),
        .slv1_len_i   (slv1_len_i),
        .slv2_len_i   (slv2_len_i),
        .f2a_ack_o    (f2a_ack_o),
        .fmt_chid_o   (fmt_chid_o),
        .fmt_length_o (fmt_length_o),
        .fmt_req_o    (fmt_req_o),
        .fmt_grant_i  (fmt_grant_i),
        .fmt_data_o   (fmt_data_o),
        .fmt_start_o  (fmt_start_o),
        .fmt_end_o    (fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] d, input logic exp_ack, input string tag);
        a2f_val_i = 1'b1;
        a2f_id_i  = id;
        a2f_dat_i = d;
        #1;
        check(tag, 32'(f2a_ack_o), 32'(exp_ack));
        tick();
        a2f_val_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"},  fmt_data_o, 32'd0);
        check({tag, "_start"}, 32'(fmt_start_o), 32'd0);
        check({tag, "_end"},   32'(fmt_end_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle_outputs(tag);
        check({tag, "_ack"},  32'(f2a_ack_o), 32'd0);
        check({tag, "_req"},  32'(fmt_req_o), 32'd0);
        check({tag, "_chid"}, 32'(fmt_chid_o), 32'd0);
        check({tag, "_len"},  32'(fmt_length_o), 32'd0);
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic s, input logic e);
        check({tag, "_data"},  fmt_data_o, d);
        check({tag, "_start"}, 32'(fmt_start_o), 32'(s));
        check({tag, "_end"},   32'(fmt_end_o), 32'(e));
        check({tag, "_req"},   32'(fmt_req_o), 32'd0);
    endtask

    task automatic grant_pulse();
        fmt_grant_i = 1'b1;
        tick();
        fmt_grant_i = 1'b0;
    endtask

    initial begin
        logic        pat_val [6];
        logic [31:0] pat_dat [6];
        logic [31:0] exp_words [4];

        pat_val   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pat_dat   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd6};
        exp_words = '{32'd0, 32'd2, 32'd4, 32'd6};

        rstn_i      = 1'b1;
        a2f_val_i   = 1'b1;
        a2f_id_i    = 2'd0;
        a2f_dat_i   = 32'd0;
        slv0_len_i  = 3'd0;
        slv1_len_i  = 3'd0;
        slv2_len_i  = 3'd0;
        fmt_grant_i = 1'b0;

        // Reset state with val held high: ack must stay low.
        #3;
        check_all_zero("rst");
        tick();
        tick();
        a2f_val_i = 1'b0;
        rstn_i    = 1'b0;

        // Partial collection with gaps in valid.
        for (int i = 0; i < 6; i++) begin
            a2f_val_i = pat_val[i];
            a2f_id_i  = 2'd0;
            a2f_dat_i = pat_dat[i];
            #1;
            check($sformatf("p1_ack%0d", i), 32'(f2a_ack_o), 32'(pat_val[i]));
            tick();
            if (i < 5) check($sformatf("p1_req%0d", i), 32'(fmt_req_o), 32'd0);
        end
        a2f_val_i = 1'b0;
        check("p1_req",  32'(fmt_req_o), 32'd1);
        check("p1_chid", 32'(fmt_chid_o), 32'd0);
        check("p1_len",  32'(fmt_length_o), 32'd4);

        // REQ holds request and blocks ack.
        a2f_val_i = 1'b1;
        a2f_dat_i = 32'd99;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("req_ack%0d", i), 32'(f2a_ack_o), 32'd0);
            tick();
            check($sformatf("req_hold%0d", i), 32'(fmt_req_o), 32'd1);
        end

        // Single-cycle grant.
        grant_pulse();
        for (int k = 0; k < 4; k++) begin
            check_word($sformatf("p1_w%0d", k), exp_words[k], k == 0, k == 3);
            check($sformatf("send_ack%0d", k), 32'(f2a_ack_o), 32'd0);
            if (k == 3) a2f_dat_i = 32'd10;
            tick();
        end
        check_idle_outputs("p1_done");
        check("p1_done_ack",  32'(f2a_ack_o), 32'd1);
        check("p1_hold_chid", 32'(fmt_chid_o), 32'd0);
        check("p1_hold_len",  32'(fmt_length_o), 32'd4);
        tick();
        a2f_val_i = 1'b0;

        // Extended grant: exactly one transfer.
        push(2'd0, 32'd11, 1'b1, "p2_ack1");
        push(2'd0, 32'd12, 1'b1, "p2_ack2");
        check("p2_req_early", 32'(fmt_req_o), 32'd0);
        push(2'd0, 32'd13, 1'b1, "p2_ack3");
        check("p2_req", 32'(fmt_req_o), 32'd1);
        fmt_grant_i = 1'b1;
        tick();
        check_word("p2_w0", 32'd10, 1'b1, 1'b0);
        tick();
        fmt_grant_i = 1'b0;
        check_word("p2_w1", 32'd11, 1'b0, 1'b0);
        tick();
        check_word("p2_w2", 32'd12, 1'b0, 1'b0);
        tick();
        check_word("p2_w3", 32'd13, 1'b0, 1'b1);
        tick();
        check_idle_outputs("p2_done");
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("p2_noreq%0d", i), 32'(fmt_req_o), 32'd0);
            check($sformatf("p2_nodat%0d", i), fmt_data_o, 32'd0);
        end

        // Invalid id is never accepted.
        push(2'd3, 32'hDEAD, 1'b0, "id3_ack");

        // Long packet on channel 1, with channel switch and mid-packet length change.
        slv1_len_i = 3'd2;
        push(2'd1, 32'h100, 1'b1, "p3_ack0");
        push(2'd2, 32'hBEEF, 1'b0, "p3_xid");
        slv1_len_i = 3'd0;
        check("p3_chid0", 32'(fmt_chid_o), 32'd1);
        check("p3_len0",  32'(fmt_length_o), 32'd16);
        for (int i = 1; i < 16; i++) begin
            push(2'd1, 32'h100 + 32'(i), 1'b1, $sformatf("p3_ack%0d", i));
            check($sformatf("p3_req%0d", i), 32'(fmt_req_o), 32'(i == 15));
        end
        check("p3_len", 32'(fmt_length_o), 32'd16);
        grant_pulse();
        for (int k = 0; k < 16; k++) begin
            check_word($sformatf("p3_w%0d", k), 32'h100 + 32'(k), k == 0, k == 15);
            tick();
        end
        check_idle_outputs("p3_done");

        // Clamped length code on channel 2, then a foreign id is refused.
        slv2_len_i = 3'd5;
        push(2'd2, 32'h200, 1'b1, "p4_ack0");
        check("p4_chid", 32'(fmt_chid_o), 32'd2);
        check("p4_len",  32'(fmt_length_o), 32'd16);
        push(2'd0, 32'h300, 1'b0, "p4_xid");

        // Reset during collection discards the partial packet.
        #2;
        rstn_i = 1'b1;
        #1;
        check_all_zero("rst_col");
        tick();
        rstn_i = 1'b0;

        // Reset during SEND.
        push(2'd0, 32'd20, 1'b1, "p5_ack0");
        push(2'd0, 32'd21, 1'b1, "p5_ack1");
        push(2'd0, 32'd22, 1'b1, "p5_ack2");
        push(2'd0, 32'd23, 1'b1, "p5_ack3");
        check("p5_req", 32'(fmt_req_o), 32'd1);
        grant_pulse();
        check_word("p5_w0", 32'd20, 1'b1, 1'b0);
        tick();
        check_word("p5_w1", 32'd21, 1'b0, 1'b0);
        a2f_val_i = 1'b1;
        a2f_id_i  = 2'd0;
        #2;
        rstn_i = 1'b1;
        #1;
        check_all_zero("rst_send");
        tick();
        check_all_zero("rst_send_hold");
        a2f_val_i = 1'b0;
        rstn_i    = 1'b0;

        // Next packet collects from an empty FIFO.
        push(2'd0, 32'd30, 1'b1, "p6_ack0");
        push(2'd0, 32'd31, 1'b1, "p6_ack1");
        push(2'd0, 32'd32, 1'b1, "p6_ack2");
        check("p6_req_early", 32'(fmt_req_o), 32'd0);
        push(2'd0, 32'd33, 1'b1, "p6_ack3");
        check("p6_req", 32'(fmt_req_o), 32'd1);
        check("p6_len", 32'(fmt_length_o), 32'd4);
        grant_pulse();
        for (int k = 0; k < 4; k++) begin
            check_word($sformatf("p6_w%0d", k), 32'd30 + 32'(k), k == 0, k == 3);
            tick();
        end
        check_idle_outputs("p6_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
